// File: rtl/tt_b14_arith_pkg.sv
// Shared arithmetic-tile definitions: divider FSM states and default operand widths
// used by both the multiplier wrapper and the sequential divider.
package tt_b14_arith_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

endpackage

// File: rtl/tt_b14_seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] prem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0]   t;
  logic [DIVISOR_W-1:0] diff;

  assign t = {prem_i, bit_i};
  // t < 2*divisor whenever it fits, so the difference always fits in DIVISOR_W bits
  assign diff = t[DIVISOR_W-1:0] - divisor_i;

  always_comb begin
    prem_o = t[DIVISOR_W-1:0];
    qbit_o = 1'b0;
    if (t >= {1'b0, divisor_i}) begin
      prem_o = diff;
      qbit_o = 1'b1;
    end
  end

endmodule

// File: rtl/tt_b14_seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_DIV0_DETECT_EN to short-circuit zero divisors and raise div0.
module tt_b14_seq_divider
  import tt_b14_arith_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div0
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  div_state_e            state_q, state_d;
  logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W-1:0]  step_prem;
  logic                  step_qbit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .prem_i    (prem_q),
    .bit_i     (shreg_q[DIVIDEND_W-1]),
    .divisor_i (dvsr_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

`ifdef DIVIDER_DIV0_DETECT_EN
  logic div0_q, div0_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef DIVIDER_DIV0_DETECT_EN
    div0_d  = div0_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIVIDER_DIV0_DETECT_EN
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend[DIVISOR_W-1:0];
            div0_d = 1'b1;
            done_d = 1'b1;
          end else
`endif
          begin
            shreg_d = dividend;
            dvsr_d  = divisor;
            prem_d  = '0;
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // The shift register drains dividend bits from the top and fills with quotient bits
        prem_d  = step_prem;
        shreg_d = {shreg_q[DIVIDEND_W-2:0], step_qbit};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = {shreg_q[DIVIDEND_W-2:0], step_qbit};
          rem_d   = step_prem;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef DIVIDER_DIV0_DETECT_EN
          div0_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef DIVIDER_DIV0_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div0_q <= 1'b0;
    else        div0_q <= div0_d;
  end
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule
